vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/vga_sync_edge.sv | 23 ++
 rtl/vga_sync_decoder.sv | 102 ++++++++++
 tb/tb_vga_sync_decoder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and the sync-decoder FSM encoding.
package vga_timing_pkg;
  localparam int H_VISIBLE     = 640;
  localparam int H_FRONT_PORCH = 16;
  localparam int H_SYNC_PULSE  = 96;
  localparam int H_BACK_PORCH  = 48;
  localparam int H_TOTAL       = 800;
  localparam int V_VISIBLE     = 480;
  localparam int V_FRONT_PORCH = 10;
  localparam int V_SYNC_PULSE  = 2;
  localparam int V_BACK_PORCH  = 33;
  localparam int V_TOTAL       = 525;

  // Counter values that coincide with the leading (falling) edge of each sync pulse.
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT_PORCH);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT_PORCH);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_e;
endpackage

// File: rtl/vga_sync_edge.sv
// Registers one active-low sync input and flags its falling edge (prev=1, cur=0).
module vga_sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic i_sync,
  output logic o_fall
);
  logic r_cur;
  logic r_prev;

  // Both stages reset high so no false fall is seen coming out of reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cur  <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_cur  <= i_sync;
      r_prev <= r_cur;
    end
  end

  assign o_fall = r_prev & ~r_cur;
endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers hc/vc position from raw hsync/vsync and tracks lock with a SEARCH/ACQUIRE/LOCKED FSM.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int LOCK_LINES = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hc_out,
  output logic [9:0] vc_out,
  output logic       is_blanking,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
);
  localparam int         CW      = (LOCK_LINES < 1) ? 1 : $clog2(LOCK_LINES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_LINES);
  localparam logic [9:0] TO_VAL  = 10'(TIMEOUT);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_PRE   = V_SYNC_START - 10'd1;
  localparam logic [9:0] H_GOOD  = 10'(H_TOTAL);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);

  logic          w_hfall, w_vfall;
  logic          w_hwrap, w_good, w_timeout, w_viol;
  logic [9:0]    r_hc, r_vc, r_period;
  logic [CW-1:0] r_good;
  logic          r_err;
  sync_state_e   r_state;

  vga_sync_edge u_hedge (.CLK(CLK), .RESET(RESET), .i_sync(hsync_in), .o_fall(w_hfall));
  vga_sync_edge u_vedge (.CLK(CLK), .RESET(RESET), .i_sync(vsync_in), .o_fall(w_vfall));

  assign w_hwrap   = (r_hc == H_LAST) && !w_hfall;
  assign w_good    = (r_period == H_GOOD);
  // A fall in the same cycle as the saturation point wins: no timeout.
  assign w_timeout = (r_period == TO_VAL) && !w_hfall;
  assign w_viol    = (w_hfall && !w_good) || w_timeout ||
                     (w_vfall && !((r_hc == H_LAST) && (r_vc == V_PRE)));

  // Position and period counters free-run in every state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hc     <= '0;
      r_vc     <= '0;
      r_period <= '0;
    end else begin
      if (w_hfall)               r_hc <= H_SYNC_START;
      else if (r_hc == H_LAST)   r_hc <= '0;
      else                       r_hc <= r_hc + 1'b1;

      if (w_vfall)               r_vc <= V_SYNC_START;
      else if (w_hwrap)          r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 1'b1;

      if (w_hfall)               r_period <= 10'd1;
      else if (r_period != TO_VAL) r_period <= r_period + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= SEARCH;
      r_good  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        SEARCH: begin
          if (w_hfall) begin
            r_state <= ACQUIRE;
            r_good  <= '0;
          end
        end
        ACQUIRE: begin
          if (w_hfall)
            r_good <= !w_good ? '0 : (r_good == CNT_MAX) ? r_good : r_good + 1'b1;
          if (w_vfall && (r_good >= CNT_MAX)) r_state <= LOCKED;
          else if (w_timeout)                 r_state <= SEARCH;
        end
        LOCKED: begin
          if (w_viol) begin
            r_err   <= 1'b1;
            r_state <= SEARCH;
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

  assign hc_out      = r_hc;
  assign vc_out      = r_vc;
  assign locked      = (r_state == LOCKED);
  assign is_blanking = !(locked && (r_hc < H_VIS) && (r_vc < V_VIS));
  assign frame_start = locked && (r_hc == '0) && (r_vc == '0);
  assign sync_err    = r_err;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: an 800x525 source model drives the decoder through lock, fault and reset scenarios.
module tb_vga_sync_decoder;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [9:0] hc_out, vc_out;
  logic       is_blanking, locked, frame_start, sync_err;

  int errors = 0, checks = 0;
  int src_hc = 0, src_vc = 0, prev_hc = 0, prev_vc = 0;
  int err_cnt = 0, fs_cnt = 0, fs_hc = -1, fs_vc = -1, track_bad = 0;
  bit h_hold = 0, v_inject = 0, dup = 0, track = 0, got = 0;
  logic fs_blank = 1'bx;

  vga_sync_decoder #(.LOCK_LINES(4), .TIMEOUT(1023)) dut (
    .CLK(CLK), .RESET(RESET), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hc_out(hc_out), .vc_out(vc_out), .is_blanking(is_blanking),
    .locked(locked), .frame_start(frame_start), .sync_err(sync_err)
  );

  always #5 CLK = ~CLK;

`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0d expected=%0d", tag, (obs), (exp)); end end

  task automatic drive();
    hsync_in = h_hold   ? 1'b1 : !(src_hc >= 656 && src_hc < 752);
    vsync_in = v_inject ? 1'b0 : !(src_vc >= 490 && src_vc < 492);
  endtask

  // One source cycle: observe the DUT just after the edge, then advance the source.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (sync_err === 1'b1) err_cnt++;
    if (frame_start === 1'b1) begin
      fs_cnt++; fs_hc = int'(hc_out); fs_vc = int'(vc_out); fs_blank = is_blanking;
    end
    if (track && (hc_out !== 10'(prev_hc) || vc_out !== 10'(prev_vc))) track_bad++;
    prev_hc = src_hc;
    prev_vc = src_vc;
    if (dup) dup = 0;
    else if (src_hc == 799) begin
      src_hc = 0;
      src_vc = (src_vc == 524) ? 0 : src_vc + 1;
    end else src_hc++;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to_hc(input int h);
    for (int i = 0; i < 801 && src_hc != h; i++) tick();
  endtask

  task automatic wait_lock(input int budget);
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (locked === 1'b1) got = 1;
    end
  endtask

  initial begin
    drive();
    repeat (3) @(posedge CLK);
    #1;
    `CHK("rst_hc", hc_out, 10'd0)
    `CHK("rst_vc", vc_out, 10'd0)
    `CHK("rst_locked", locked, 1'b0)
    `CHK("rst_blank", is_blanking, 1'b1)
    `CHK("rst_fs", frame_start, 1'b0)
    `CHK("rst_serr", sync_err, 1'b0)

    // Standard stream: lock at the first vsync fall, then follow to the frame start.
    src_hc = 0; src_vc = 483; drive();
    RESET = 1'b0;
    wait_lock(8000);
    `CHK("A_lock", got, 1'b1)
    `CHK("A_lock_hc", hc_out, 10'd0)
    `CHK("A_lock_vc", vc_out, 10'd490)
    `CHK("A_lock_blank", is_blanking, 1'b1)
    track = 1; track_bad = 0;
    for (int i = 0; i < 30000 && fs_cnt == 0; i++) tick();
    `CHK("A_fs_cnt", fs_cnt, 1)
    `CHK("A_fs_hc", fs_hc, 0)
    `CHK("A_fs_vc", fs_vc, 0)
    `CHK("A_fs_blank", fs_blank, 1'b0)
    `CHK("A_track", track_bad, 0)
    `CHK("A_serr", err_cnt, 0)

    // hsync stuck high: single timeout error, then relock.
    track = 0; err_cnt = 0;
    h_hold = 1; drive();
    run(1500);
    `CHK("B_serr", err_cnt, 1)
    `CHK("B_locked", locked, 1'b0)
    `CHK("B_blank", is_blanking, 1'b1)
    h_hold = 0; src_vc = 483; drive();
    wait_lock(8000);
    `CHK("B_relock", got, 1'b1)
    `CHK("B_relock_hc", hc_out, 10'd0)
    `CHK("B_relock_vc", vc_out, 10'd490)
    `CHK("B_serr_after", err_cnt, 1)

    // One 801-cycle line while locked.
    err_cnt = 0; track_bad = 0; track = 1;
    run(3200);
    run_to_hc(799);
    `CHK("C_track", track_bad, 0)
    track = 0; dup = 1;
    run(1600);
    `CHK("C_serr", err_cnt, 1)
    `CHK("C_locked", locked, 1'b0)
    src_vc = 483; drive();
    wait_lock(8000);
    `CHK("C_relock", got, 1'b1)
    `CHK("C_relock_vc", vc_out, 10'd490)
    `CHK("C_serr_after", err_cnt, 1)

    // Spurious vsync fall at source line 300.
    err_cnt = 0;
    src_vc = 299; drive();
    run_to_hc(0);
    v_inject = 1; drive();
    run(800);
    v_inject = 0; drive();
    `CHK("D_serr", err_cnt, 1)
    `CHK("D_locked", locked, 1'b0)
    `CHK("D_blank", is_blanking, 1'b1)
    src_vc = 483; drive();
    wait_lock(8000);
    `CHK("D_relock", got, 1'b1)
    `CHK("D_relock_hc", hc_out, 10'd0)

    // Reset mid-frame at source (320,200): outputs drop at once, then reacquire.
    err_cnt = 0;
    src_vc = 200; drive();
    run_to_hc(320);
    RESET = 1'b1;
    #1;
    `CHK("E_rst_hc", hc_out, 10'd0)
    `CHK("E_rst_vc", vc_out, 10'd0)
    `CHK("E_rst_locked", locked, 1'b0)
    `CHK("E_rst_blank", is_blanking, 1'b1)
    `CHK("E_rst_fs", frame_start, 1'b0)
    `CHK("E_rst_serr", sync_err, 1'b0)
    run(3);
    RESET = 1'b0;
    run(2);
    `CHK("E_post_locked", locked, 1'b0)
    src_vc = 483; drive();
    wait_lock(8000);
    `CHK("E_relock", got, 1'b1)
    `CHK("E_relock_hc", hc_out, 10'd0)
    `CHK("E_relock_vc", vc_out, 10'd490)
    `CHK("E_serr", err_cnt, 0)

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
